nrs_gold_seq_gen: RTL and testbench

//  Upstream feeder of the channel-estimation complex multiplier. Generates the QPSK

---
 rtl/nrs_pkg.sv | 46 ++++
 rtl/nrs_gold_lfsr.sv | 48 ++++
 rtl/nrs_gold_seq_gen.sv | 144 ++++++++++++++
 tb/tb_nrs_gold_seq_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
// Shared definitions for the NB-IoT NRS Gold-sequence generator.
//   - Sequence constants: NC, M_PRIME_BASE, NUM_SYM, SKIP_LEN
//   - LFSR feedback tap masks for x1 and x2
//   - FSM state encoding
//   - calc_c_init(): scrambler initialisation from slot, symbol and cell ID
//   - lfsr_step(): one step of a Fibonacci LFSR given its tap mask
package nrs_pkg;

  localparam int NC           = 1600;
  localparam int M_PRIME_BASE = 109;
  localparam int NUM_SYM      = 2;
  localparam int SKIP_LEN     = NC + 2 * M_PRIME_BASE;  // 1818
  localparam int CNT_W        = 11;

  // Register bit i holds x(n+i); the feedback bit is the XOR of the masked bits.
  // x1: x(n+31) = x(n+3) ^ x(n)
  // x2: x(n+31) = x(n+3) ^ x(n+2) ^ x(n+1) ^ x(n)
  localparam logic [30:0] X1_TAPS = 31'h0000_0009;
  localparam logic [30:0] X2_TAPS = 31'h0000_000F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SKIP = 2'd2,
    EMIT = 2'd3
  } state_t;

  // c_init = 2^10 * (7*(ns+1) + l_sym + 1) * (2*n_id + 1) + 2*n_id + 1
  // Largest in-range value is 151,582,703, which fits in 31 bits.
  function automatic logic [30:0] calc_c_init(input logic [4:0] ns,
                                              input logic [2:0] l_sym,
                                              input logic [8:0] n_id);
    logic [30:0] sym_term;
    logic [30:0] id_term;
    sym_term = 31'd7 * ({26'd0, ns} + 31'd1) + {28'd0, l_sym} + 31'd1;
    id_term  = {21'd0, n_id, 1'b1};
    return ((sym_term * id_term) << 10) + id_term;
  endfunction

  // Shift toward bit 0 and insert the new feedback bit at the top.
  function automatic logic [30:0] lfsr_step(input logic [30:0] x,
                                            input logic [30:0] taps);
    return {^(x & taps), x[30:1]};
  endfunction

endpackage

// File: rtl/nrs_gold_lfsr.sv
// Gold-sequence LFSR pair (x1, x2) for the NRS generator.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset (x1 = x2 = 0)
//   load    in   load x1 = 1, x2 = c_init (highest priority)
//   c_init  in   31-bit x2 initial value
//   step    in   advance both registers by one step
//   step2   in   advance both registers by two steps (wins over step)
//   c_bit0  out  c at the current position, x1[0] ^ x2[0]
//   c_bit1  out  c one step ahead, x1[1] ^ x2[1]
module nrs_gold_lfsr
  import nrs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [30:0] c_init,
  input  logic        step,
  input  logic        step2,
  output logic        c_bit0,
  output logic        c_bit1
);

  logic [30:0] x1;
  logic [30:0] x2;

  always_ff @(posedge clk) begin
    if (rst) begin
      x1 <= '0;
      x2 <= '0;
    end else if (load) begin
      x1 <= 31'd1;
      x2 <= c_init;
    end else if (step2) begin
      x1 <= lfsr_step(lfsr_step(x1, X1_TAPS), X1_TAPS);
      x2 <= lfsr_step(lfsr_step(x2, X2_TAPS), X2_TAPS);
    end else if (step) begin
      x1 <= lfsr_step(x1, X1_TAPS);
      x2 <= lfsr_step(x2, X2_TAPS);
    end
  end

  // Bit 1 of each register is already the value one step ahead, so both
  // bits of a QPSK symbol are available without an extra cycle.
  assign c_bit0 = x1[0] ^ x2[0];
  assign c_bit1 = x1[1] ^ x2[1];

endmodule

// File: rtl/nrs_gold_seq_gen.sv
// NB-IoT NRS QPSK sign-bit generator (one OFDM symbol per start).
// Emits NUM_SYM symbols {nrs_r, nrs_i} = {c(2m'), c(2m'+1)}, m' = m + M_PRIME_BASE,
// where c is the Gold sequence seeded from (ns, l_sym, n_id). A bit of 1 means a
// negative component.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle request; ns/l_sym/n_id sampled when accepted
//   ns, l_sym, n_id slot (0..19), OFDM symbol (5/6), NCellID (0..503)
//   busy            high from accepted start until the final symbol handshake
//   cfg_err         one-cycle pulse when a start is rejected for out-of-range inputs
//   out_valid       nrs_r/nrs_i/sym_idx valid
//   out_ready       consumer accept; handshake = out_valid & out_ready
//   nrs_r, nrs_i    sign bits of the current symbol
//   sym_idx         symbol index m
// Configuration macro: NRS_GEN_DUAL_STEP_EN -- advance the LFSRs two steps per
// cycle while skipping (out_valid 911 cycles after start instead of 1820).
module nrs_gold_seq_gen
  import nrs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] ns,
  input  logic [2:0] l_sym,
  input  logic [8:0] n_id,
  output logic       busy,
  output logic       cfg_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       nrs_r,
  output logic       nrs_i,
  output logic       sym_idx
);

`ifdef NRS_GEN_DUAL_STEP_EN
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_LEN / 2 - 1);
  localparam logic             SKIP_DUAL = 1'b1;
`else
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_LEN - 1);
  localparam logic             SKIP_DUAL = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] skip_cnt;
  logic [4:0]       ns_q;
  logic [2:0]       l_sym_q;
  logic [8:0]       n_id_q;
  logic             cfg_ok;
  logic             last_sym;
  logic             emit_take;
  logic             lfsr_load;
  logic             lfsr_step1;
  logic             lfsr_step2;
  logic             c_bit0;
  logic             c_bit1;

  assign cfg_ok   = (ns <= 5'd19) && ((l_sym == 3'd5) || (l_sym == 3'd6)) && (n_id <= 9'd503);
  assign last_sym = (sym_idx == 1'(NUM_SYM - 1));

  // In EMIT the LFSR always points at the symbol after the one on the outputs.
  // The output register loads on the first EMIT cycle and on every non-final
  // handshake, and each load moves the LFSR on by one symbol (two steps).
  assign emit_take  = (state == EMIT) && (!out_valid || (out_ready && !last_sym));
  assign lfsr_load  = (state == INIT);
  assign lfsr_step1 = (state == SKIP) && !SKIP_DUAL;
  assign lfsr_step2 = ((state == SKIP) && SKIP_DUAL) || emit_take;

  nrs_gold_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .c_init (calc_c_init(ns_q, l_sym_q, n_id_q)),
    .step   (lfsr_step1),
    .step2  (lfsr_step2),
    .c_bit0 (c_bit0),
    .c_bit1 (c_bit1)
  );

  // Captured configuration; only consumed in INIT, so no reset needed.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start && cfg_ok) begin
      ns_q    <= ns;
      l_sym_q <= l_sym;
      n_id_q  <= n_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      nrs_r     <= 1'b0;
      nrs_i     <= 1'b0;
      sym_idx   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              busy  <= 1'b1;
              state <= INIT;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        INIT: begin
          skip_cnt <= '0;
          state    <= SKIP;
        end
        // ---- skip NC + 2*M_PRIME_BASE sequence steps ----
        SKIP: begin
          if (skip_cnt == SKIP_LAST) begin
            state <= EMIT;
          end else begin
            skip_cnt <= skip_cnt + 1'b1;
          end
        end
        // ---- output register / handshake ----
        EMIT: begin
          if (emit_take) begin
            nrs_r     <= c_bit0;
            nrs_i     <= c_bit1;
            out_valid <= 1'b1;
          end
          if (out_valid && out_ready) begin
            sym_idx <= sym_idx + 1'b1;
            if (last_sym) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Directed bench for nrs_gold_seq_gen: a table of configurations (valid and
// out-of-range) plus hand-written multi-cycle sequences for stall, start while
// busy, start on the final handshake and mid-run reset. Expected bits come from
// a direct array evaluation of the Gold-sequence recurrences.
// Build with NRS_GEN_DUAL_STEP_EN defined to target the dual-step datapath.
module tb_nrs_gold_seq_gen;

`ifdef NRS_GEN_DUAL_STEP_EN
  localparam int LAT = 911;
`else
  localparam int LAT = 1820;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] ns;
  logic [2:0] l_sym;
  logic [8:0] n_id;
  logic       out_ready;
  logic       busy;
  logic       cfg_err;
  logic       out_valid;
  logic       nrs_r;
  logic       nrs_i;
  logic       sym_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nrs_gold_seq_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ns        (ns),
    .l_sym     (l_sym),
    .n_id      (n_id),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .nrs_r     (nrs_r),
    .nrs_i     (nrs_i),
    .sym_idx   (sym_idx)
  );

  typedef struct {
    logic [4:0]  ns;
    logic [2:0]  l_sym;
    logic [8:0]  n_id;
    logic        exp_err;
    logic [30:0] exp_cinit;
    logic        hold_ready;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // c(218..221) from the recurrences written out over a plain bit array.
  function automatic logic [3:0] gold_bits(input logic [30:0] cinit);
    logic       x1 [0:1851];
    logic       x2 [0:1851];
    logic [3:0] r;
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = cinit[i];
    end
    for (int n = 0; n < 1852 - 31; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int k = 0; k < 4; k++) r[k] = x1[1600+218+k] ^ x2[1600+218+k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] a, input logic [2:0] b, input logic [8:0] c);
    start = 1'b1;
    ns    = a;
    l_sym = b;
    n_id  = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < LAT + 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_valid(input logic [4:0] a, input logic [2:0] b, input logic [8:0] c,
                           input logic [30:0] cinit, input logic hold_ready,
                           input logic stall, input logic late_start);
    logic [3:0] exp;
    int         lat;
    exp       = gold_bits(cinit);
    out_ready = hold_ready;
    do_start(a, b, c);
    chk("busy_after_start", busy, 1);
    chk("no_cfg_err", cfg_err, 0);
    wait_valid(lat);
    chk("latency", lat, LAT);
    for (int m = 0; m < 2; m++) begin
      chk("out_valid", out_valid, 1);
      chk("sym_idx", sym_idx, m);
      chk("nrs_r", nrs_r, exp[2*m]);
      chk("nrs_i", nrs_i, exp[2*m+1]);
      if (stall && m == 0) begin
        repeat (10) begin
          tick();
          chk("stall_hold", {out_valid, sym_idx, nrs_r, nrs_i}, {1'b1, 1'b0, exp[0], exp[1]});
        end
      end
      if (!hold_ready) begin
        out_ready = 1'b1;
        if (late_start && m == 1) begin
          start = 1'b1;
          ns    = a;
          l_sym = b;
          n_id  = c;
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
      end else begin
        tick();
      end
    end
    chk("valid_drop", out_valid, 0);
    chk("busy_drop", busy, 0);
    out_ready = 1'b0;
    if (late_start) begin
      tick();
      chk("late_start_ignored", busy, 0);
    end
  endtask

  task automatic run_err(input logic [4:0] a, input logic [2:0] b, input logic [8:0] c);
    do_start(a, b, c);
    chk("cfg_err_pulse", cfg_err, 1);
    chk("err_busy", busy, 0);
    tick();
    chk("cfg_err_clear", cfg_err, 0);
    repeat (3) tick();
    chk("err_no_valid", {busy, out_valid}, 0);
  endtask

  initial begin
    logic [3:0] exp;
    int         lat;

    vecs[0] = '{5'd0,  3'd5, 9'd0,   1'b0, 31'd13313,     1'b0};
    vecs[1] = '{5'd19, 3'd6, 9'd503, 1'b0, 31'd151582703, 1'b1};
    vecs[2] = '{5'd7,  3'd6, 9'd100, 1'b0, 31'd12967113,  1'b0};
    vecs[3] = '{5'd3,  3'd5, 9'd255, 1'b0, 31'd17791487,  1'b1};
    vecs[4] = '{5'd10, 3'd5, 9'd1,   1'b0, 31'd254979,    1'b0};
    vecs[5] = '{5'd0,  3'd5, 9'd504, 1'b1, 31'd0,         1'b0};
    vecs[6] = '{5'd20, 3'd5, 9'd0,   1'b1, 31'd0,         1'b0};
    vecs[7] = '{5'd0,  3'd4, 9'd0,   1'b1, 31'd0,         1'b0};
    vecs[8] = '{5'd0,  3'd7, 9'd0,   1'b1, 31'd0,         1'b0};
    vecs[9] = '{5'd31, 3'd6, 9'd511, 1'b1, 31'd0,         1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    ns        = '0;
    l_sym     = '0;
    n_id      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {busy, cfg_err, out_valid, nrs_r, nrs_i, sym_idx}, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].exp_err)
        run_err(vecs[v].ns, vecs[v].l_sym, vecs[v].n_id);
      else
        run_valid(vecs[v].ns, vecs[v].l_sym, vecs[v].n_id, vecs[v].exp_cinit,
                  vecs[v].hold_ready, 1'b0, 1'b0);
      tick();
    end

    // Consumer stall of 10 cycles on the first symbol.
    run_valid(5'd7, 3'd6, 9'd100, 31'd12967113, 1'b0, 1'b1, 1'b0);
    tick();

    // Start presented in the same cycle as the final handshake.
    run_valid(5'd0, 3'd5, 9'd0, 31'd13313, 1'b0, 1'b0, 1'b1);
    tick();

    // Starts while busy (valid and out-of-range) are ignored silently.
    exp = gold_bits(31'd13313);
    do_start(5'd0, 3'd5, 9'd0);
    repeat (10) tick();
    do_start(5'd7, 3'd6, 9'd100);
    chk("busy_start_no_err", cfg_err, 0);
    do_start(5'd0, 3'd5, 9'd504);
    chk("busy_bad_start_no_err", cfg_err, 0);
    chk("busy_held", busy, 1);
    out_ready = 1'b1;
    wait_valid(lat);
    chk("busy_start_latency", lat + 12, LAT);
    chk("busy_start_sym0", {sym_idx, nrs_r, nrs_i}, {1'b0, exp[0], exp[1]});
    tick();
    chk("busy_start_sym1", {sym_idx, nrs_r, nrs_i}, {1'b1, exp[2], exp[3]});
    tick();
    chk("busy_start_done", {busy, out_valid}, 0);
    out_ready = 1'b0;
    tick();

    // Reset 500 cycles into SKIP discards the run; a fresh start is clean.
    do_start(5'd3, 3'd5, 9'd255);
    repeat (501) tick();
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outputs", {busy, cfg_err, out_valid, nrs_r, nrs_i, sym_idx}, 0);
    repeat (5) tick();
    chk("idle_after_rst", {busy, out_valid}, 0);
    run_valid(5'd0, 3'd5, 9'd0, 31'd13313, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
